periph_msg_fifo: RTL and testbench
==================================

PERIPH_MSG_FIFO -- requirements
Module: periph_msg_fifo

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter DATA_WIDTH, default 32: entry and bus data width.
REQ-003 Parameter ADDR_WIDTH, default 32: peripheral address width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 data_req_i  in  1  peripheral request, from the peripheral demux MYF port.
REQ-007 data_add_i  in  ADDR_WIDTH  byte address; only bits [3:2] decoded.
REQ-008 data_wen_i  in  1  1 = read, 0 = write.
REQ-009 data_wdata_i  in  DATA_WIDTH  write data.
REQ-010 data_be_i  in  DATA_WIDTH/8  byte enables; ignored.
REQ-011 data_gnt_o  out  1  grant.
REQ-012 data_r_valid_o  out  1  response valid.
REQ-013 data_r_rdata_o  out  DATA_WIDTH  read data.
REQ-014 data_r_opc_o  out  1  response error flag.
REQ-015 push_valid_i  in  1  neighbour enqueue valid.
REQ-016 push_data_i  in  DATA_WIDTH  neighbour enqueue data.
REQ-017 push_ready_o  out  1  enqueue accepted when high with push_valid_i.
REQ-018 not_empty_o  out  1  level event to event unit: FIFO holds >=1 entry.

Function
REQ-019 Storage SHALL be a circular buffer with read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH and a count register of log2(DEPTH)+1 bits (0..DEPTH).
REQ-020 data_gnt_o SHALL equal data_req_i combinationally; every request is granted in its request cycle.
REQ-021 Every granted request SHALL produce exactly one data_r_valid_o pulse on the following cycle; no response without a preceding grant.
REQ-022 Register map by data_add_i[3:2]: 0 DATA, 1 STATUS, 2 CTRL, 3 unmapped.
REQ-023 DATA read, FIFO non-empty: head entry registered into data_r_rdata_o, read pointer +1, count -1, opc 0.
REQ-024 DATA read, FIFO empty: no pointer change, rdata 0, opc 1.
REQ-025 DATA write: no state change, opc 1.
REQ-026 STATUS read: rdata[15:0] = count, [16] = empty, [17] = full, other bits 0, opc 0; sampled in the request cycle, before that cycle's push.
REQ-027 STATUS write: ignored, opc 0.
REQ-028 CTRL write with wdata[0]=1: flush (pointers and count to 0) at end of cycle; wdata[0]=0 no effect; opc 0.
REQ-029 CTRL read: rdata 0, opc 0.
REQ-030 Unmapped read or write: no state change, rdata 0, opc 1.
REQ-031 When data_r_valid_o is low, data_r_rdata_o SHALL be 0 and data_r_opc_o 0.
REQ-032 push_ready_o = (count != DEPTH) AND NOT (granted CTRL flush write this cycle); push occurs when push_valid_i AND push_ready_o: entry written at write pointer, write pointer +1.
REQ-033 Simultaneous push and pop: both occur; count unchanged.
REQ-034 Full and pop in same cycle: push_ready_o stays low that cycle (no bypass); pop proceeds.
REQ-035 Empty and push in same cycle as DATA read: read returns empty error (no fall-through); push proceeds.
REQ-036 Flush in same cycle as push_valid_i: flush wins, push not accepted (ready low).
REQ-037 not_empty_o SHALL be registered-derived: (count != 0), no combinational path from inputs.

Reset
REQ-038 On rst_ni low, asynchronously: pointers 0, count 0, data_r_valid_o 0, data_r_rdata_o 0, data_r_opc_o 0, not_empty_o 0; storage contents need not be cleared.
REQ-039 Reset asserted mid-transaction SHALL drop any pending response; first post-reset cycle has data_r_valid_o 0, push_ready_o 1.

Verification
REQ-040 Push 0xA1, 0xA2, 0xA3; three DATA reads (addr 0x0) -> rdata 0xA1, 0xA2, 0xA3, opc 0, each valid one cycle after grant; then not_empty_o 0.
REQ-041 DEPTH=8: push 8 words -> push_ready_o 0, STATUS reads 0x0002_0008; push held 3 cycles not accepted; one pop -> push_ready_o 1 next cycle.
REQ-042 DATA read on empty FIFO -> r_valid 1, rdata 0, opc 1; STATUS then 0x0001_0000.
REQ-043 Push 12 words with interleaved pops keeping count <= 8 (pointer wrap) -> all 12 popped in order, no loss.
REQ-044 Count 5, CTRL write 0x1 with push_valid_i high same cycle -> push rejected, next STATUS = 0x0001_0000; write to addr 0xC -> opc 1.
REQ-045 Reset asserted in cycle between DATA read grant and response -> no r_valid, count 0, not_empty_o 0.

Source files
------------

// File: rtl/periph_msg_fifo.sv
// rtl/periph_msg_fifo.sv - message FIFO with neighbour push port and peripheral-bus pop/status/control
module periph_msg_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_add_i,
  input  logic                    data_wen_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  output logic                    data_gnt_o,
  output logic                    data_r_valid_o,
  output logic [DATA_WIDTH-1:0]   data_r_rdata_o,
  output logic                    data_r_opc_o,
  input  logic                    push_valid_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  output logic                    push_ready_o,
  output logic                    not_empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
  logic                  r_opc_q, r_opc_d;

  logic [1:0]            reg_sel;
  logic                  is_empty, is_full;
  logic                  flush, pop, push;
  logic [DATA_WIDTH-1:0] status_word;

  // Address bits outside [3:2], byte enables and upper CTRL bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{data_be_i, data_add_i[ADDR_WIDTH-1:4], data_add_i[1:0],
                         data_wdata_i[DATA_WIDTH-1:1]};

  assign reg_sel    = data_add_i[3:2];
  assign is_empty   = (count_q == '0);
  assign is_full    = (count_q == CW'(DEPTH));

  // Every request is accepted in the cycle it is presented.
  assign data_gnt_o = data_req_i;

  // Flush beats an incoming push; a pop never frees room for a same-cycle push (no bypass).
  assign flush        = data_req_i && !data_wen_i && (reg_sel == SEL_CTRL) && data_wdata_i[0];
  assign pop          = data_req_i && data_wen_i && (reg_sel == SEL_DATA) && !is_empty;
  assign push_ready_o = !is_full && !flush;
  assign push         = push_valid_i && push_ready_o;

  assign not_empty_o  = !is_empty;

  assign data_r_valid_o = r_valid_q;
  assign data_r_rdata_o = r_rdata_q;
  assign data_r_opc_o   = r_opc_q;

  // Status snapshot reflects the level before this cycle's push/pop.
  always_comb begin
    status_word       = '0;
    status_word[15:0] = 16'(count_q);
    status_word[16]   = is_empty;
    status_word[17]   = is_full;
  end

  // Decode the bus access into the response that will appear next cycle.
  always_comb begin
    r_valid_d = data_req_i;
    r_rdata_d = '0;
    r_opc_d   = 1'b0;
    if (data_req_i) begin
      unique case (reg_sel)
        SEL_DATA: begin
          if (!data_wen_i) begin
            r_opc_d = 1'b1;
          end else if (is_empty) begin
            r_opc_d = 1'b1;
          end else begin
            r_rdata_d = mem_q[rd_ptr_q];
          end
        end
        SEL_STATUS: begin
          if (data_wen_i) r_rdata_d = status_word;
        end
        SEL_CTRL: begin
          r_rdata_d = '0;
        end
        default: begin
          r_opc_d = 1'b1;
        end
      endcase
    end
  end

  // Pointer and level update; flush clears everything regardless of push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state and registered bus response.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      r_valid_q <= 1'b0;
      r_rdata_q <= '0;
      r_opc_q   <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      r_valid_q <= r_valid_d;
      r_rdata_q <= r_rdata_d;
      r_opc_q   <= r_opc_d;
    end
  end

  // Storage array; contents are don't-care until written, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: tb/tb_periph_msg_fifo.sv
// tb/tb_periph_msg_fifo.sv - scoreboard bench for periph_msg_fifo
module tb_periph_msg_fifo;

  logic        clk;
  logic        rst_ni;
  logic        data_req_i;
  logic [31:0] data_add_i;
  logic        data_wen_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o;
  logic        data_r_valid_o;
  logic [31:0] data_r_rdata_o;
  logic        data_r_opc_o;
  logic        push_valid_i;
  logic [31:0] push_data_i;
  logic        push_ready_o;
  logic        not_empty_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];

  logic        acc, gnt, rv, opc;
  logic [31:0] rd, exp_d;
  logic        exp_e;

  periph_msg_fifo #(.DEPTH(8), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst_ni         (rst_ni),
    .data_req_i     (data_req_i),
    .data_add_i     (data_add_i),
    .data_wen_i     (data_wen_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_gnt_o     (data_gnt_o),
    .data_r_valid_o (data_r_valid_o),
    .data_r_rdata_o (data_r_rdata_o),
    .data_r_opc_o   (data_r_opc_o),
    .push_valid_i   (push_valid_i),
    .push_data_i    (push_data_i),
    .push_ready_o   (push_ready_o),
    .not_empty_o    (not_empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; accepted pushes enter the scoreboard, response sampled 1ns after the edge.
  task automatic cyc(input logic req, input logic [31:0] addr, input logic wen,
                     input logic [31:0] wd, input logic pv, input logic [31:0] pd,
                     output logic a, output logic g, output logic v,
                     output logic [31:0] d, output logic e);
    data_req_i   = req;
    data_add_i   = addr;
    data_wen_i   = wen;
    data_wdata_i = wd;
    push_valid_i = pv;
    push_data_i  = pd;
    #1;
    a = pv && push_ready_o;
    g = data_gnt_o;
    @(posedge clk);
    #1;
    v = data_r_valid_o;
    d = data_r_rdata_o;
    e = data_r_opc_o;
    data_req_i   = 1'b0;
    data_wen_i   = 1'b0;
    data_add_i   = '0;
    data_wdata_i = '0;
    push_valid_i = 1'b0;
    if (a) sb.push_back(pd);
  endtask

  // Expected outcome of a DATA read given the scoreboard contents before the cycle.
  task automatic sb_expect(output logic [31:0] d, output logic e);
    if (sb.size() > 0) begin
      d = sb.pop_front();
      e = 1'b0;
    end else begin
      d = '0;
      e = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[15:0]  = 16'(sb.size());
    s[16]    = (sb.size() == 0);
    s[17]    = (sb.size() == 8);
    return s;
  endfunction

  task automatic test_reset();
    n_checks++; if (data_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %0b exp 0", data_r_valid_o); end
    n_checks++; if (data_r_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", data_r_rdata_o); end
    n_checks++; if (data_r_opc_o !== 1'b0) begin n_fail++; $display("FAIL reset_opc got %0b exp 0", data_r_opc_o); end
    n_checks++; if (not_empty_o !== 1'b0) begin n_fail++; $display("FAIL reset_not_empty got %0b exp 0", not_empty_o); end
    n_checks++; if (push_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready got %0b exp 1", push_ready_o); end
  endtask

  task automatic test_basic();
    logic [31:0] vals [3] = '{32'hA1, 32'hA2, 32'hA3};
    foreach (vals[i]) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, vals[i], acc, gnt, rv, rd, opc);
      n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_push_acc got %0b exp 1", acc); end
      n_checks++; if (rv !== 1'b0) begin n_fail++; $display("FAIL basic_idle_rvalid got %0b exp 0", rv); end
    end
    n_checks++; if (not_empty_o !== 1'b1) begin n_fail++; $display("FAIL basic_not_empty got %0b exp 1", not_empty_o); end
    for (int i = 0; i < 3; i++) begin
      sb_expect(exp_d, exp_e);
      cyc(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
      n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL basic_gnt got %0b exp 1", gnt); end
      n_checks++; if (rv !== 1'b1) begin n_fail++; $display("FAIL basic_rvalid got %0b exp 1", rv); end
      n_checks++; if (rd !== exp_d) begin n_fail++; $display("FAIL basic_rdata got %h exp %h", rd, exp_d); end
      n_checks++; if (opc !== exp_e) begin n_fail++; $display("FAIL basic_opc got %0b exp %0b", opc, exp_e); end
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL basic_idle_gnt got %0b exp 0", gnt); end
    n_checks++; if ({rv, rd, opc} !== 34'h0) begin n_fail++; $display("FAIL basic_idle_resp got %0b/%h/%0b exp 0/0/0", rv, rd, opc); end
    n_checks++; if (not_empty_o !== 1'b0) begin n_fail++; $display("FAIL basic_drained_not_empty got %0b exp 0", not_empty_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100 + i, acc, gnt, rv, rd, opc);
      n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL full_fill_acc i=%0d got %0b exp 1", i, acc); end
    end
    n_checks++; if (push_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b exp 0", push_ready_o); end
    cyc(1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if (rd !== 32'h0002_0008 || rd !== exp_status()) begin n_fail++; $display("FAIL full_status got %h exp 00020008", rd); end
    n_checks++; if (opc !== 1'b0) begin n_fail++; $display("FAIL full_status_opc got %0b exp 0", opc); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD, acc, gnt, rv, rd, opc);
      n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL full_held_acc i=%0d got %0b exp 0", i, acc); end
    end
    // Pop while full with push offered: no bypass, ready stays low this cycle.
    sb_expect(exp_d, exp_e);
    cyc(1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 32'hBEEF, acc, gnt, rv, rd, opc);
    n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL full_pop_bypass got %0b exp 0", acc); end
    n_checks++; if (rd !== exp_d || opc !== exp_e) begin n_fail++; $display("FAIL full_pop_data got %h/%0b exp %h/%0b", rd, opc, exp_d, exp_e); end
    n_checks++; if (push_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop got %0b exp 1", push_ready_o); end
    while (sb.size() > 0) begin
      sb_expect(exp_d, exp_e);
      cyc(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
      n_checks++; if (rd !== exp_d || opc !== exp_e) begin n_fail++; $display("FAIL full_drain got %h/%0b exp %h/%0b", rd, opc, exp_d, exp_e); end
    end
  endtask

  task automatic test_empty();
    cyc(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if ({rv, rd, opc} !== {1'b1, 32'h0, 1'b1}) begin n_fail++; $display("FAIL empty_read got %0b/%h/%0b exp 1/0/1", rv, rd, opc); end
    cyc(1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if (rd !== 32'h0001_0000) begin n_fail++; $display("FAIL empty_status got %h exp 00010000", rd); end
    // Push into an empty FIFO alongside a DATA read: read errors, push still lands.
    cyc(1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 32'h55, acc, gnt, rv, rd, opc);
    n_checks++; if ({acc, rd, opc} !== {1'b1, 32'h0, 1'b1}) begin n_fail++; $display("FAIL empty_fallthrough got %0b/%h/%0b exp 1/0/1", acc, rd, opc); end
    sb_expect(exp_d, exp_e);
    cyc(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if (rd !== exp_d || opc !== exp_e) begin n_fail++; $display("FAIL empty_late_pop got %h/%0b exp %h/%0b", rd, opc, exp_d, exp_e); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) begin
      if (i >= 5) begin
        sb_expect(exp_d, exp_e);
        cyc(1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 32'h200 + i, acc, gnt, rv, rd, opc);
        n_checks++; if (rd !== exp_d || opc !== exp_e) begin n_fail++; $display("FAIL wrap_pop i=%0d got %h/%0b exp %h/%0b", i, rd, opc, exp_d, exp_e); end
      end else begin
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200 + i, acc, gnt, rv, rd, opc);
      end
      n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL wrap_push i=%0d got %0b exp 1", i, acc); end
    end
    cyc(1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if (rd !== exp_status()) begin n_fail++; $display("FAIL wrap_status got %h exp %h", rd, exp_status()); end
    while (sb.size() > 0) begin
      sb_expect(exp_d, exp_e);
      cyc(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
      n_checks++; if (rd !== exp_d || opc !== exp_e) begin n_fail++; $display("FAIL wrap_drain got %h/%0b exp %h/%0b", rd, opc, exp_d, exp_e); end
    end
  endtask

  task automatic test_flush_regs();
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h300 + i, acc, gnt, rv, rd, opc);
    // CTRL write 0 must leave the contents alone.
    cyc(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if (opc !== 1'b0) begin n_fail++; $display("FAIL ctrl_nop_opc got %0b exp 0", opc); end
    cyc(1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if (rd !== 32'h0000_0005) begin n_fail++; $display("FAIL flush_pre_status got %h exp 00000005", rd); end
    cyc(1'b1, 32'h8, 1'b0, 32'h1, 1'b1, 32'hF00D, acc, gnt, rv, rd, opc);
    sb.delete();
    n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL flush_push_acc got %0b exp 0", acc); end
    n_checks++; if (opc !== 1'b0) begin n_fail++; $display("FAIL flush_opc got %0b exp 0", opc); end
    cyc(1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if (rd !== 32'h0001_0000) begin n_fail++; $display("FAIL flush_status got %h exp 00010000", rd); end
    cyc(1'b1, 32'hC, 1'b0, 32'h1, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if ({rv, opc} !== 2'b11) begin n_fail++; $display("FAIL unmapped_wr got %0b/%0b exp 1/1", rv, opc); end
    cyc(1'b1, 32'hC, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if ({rd, opc} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL unmapped_rd got %h/%0b exp 0/1", rd, opc); end
    cyc(1'b1, 32'h8, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if ({rd, opc} !== {32'h0, 1'b0}) begin n_fail++; $display("FAIL ctrl_rd got %h/%0b exp 0/0", rd, opc); end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h77, acc, gnt, rv, rd, opc);
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if (opc !== 1'b1) begin n_fail++; $display("FAIL data_wr_opc got %0b exp 1", opc); end
    cyc(1'b1, 32'h4, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if ({rd, opc} !== {32'h0, 1'b0}) begin n_fail++; $display("FAIL status_wr got %h/%0b exp 0/0", rd, opc); end
    cyc(1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if (rd !== exp_status()) begin n_fail++; $display("FAIL post_write_status got %h exp %h", rd, exp_status()); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h401, acc, gnt, rv, rd, opc);
    data_req_i = 1'b1;
    data_add_i = 32'h0;
    data_wen_i = 1'b1;
    @(posedge clk);
    #2;
    data_req_i = 1'b0;
    data_wen_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    sb.delete();
    n_checks++; if (data_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid got %0b exp 0", data_r_valid_o); end
    n_checks++; if (not_empty_o !== 1'b0) begin n_fail++; $display("FAIL midrst_not_empty got %0b exp 0", not_empty_o); end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    #1;
    n_checks++; if ({data_r_valid_o, push_ready_o} !== 2'b01) begin n_fail++; $display("FAIL midrst_post got %0b/%0b exp 0/1", data_r_valid_o, push_ready_o); end
    cyc(1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, acc, gnt, rv, rd, opc);
    n_checks++; if (rd !== 32'h0001_0000) begin n_fail++; $display("FAIL midrst_status got %h exp 00010000", rd); end
  endtask

  initial begin
    rst_ni       = 1'b0;
    data_req_i   = 1'b0;
    data_add_i   = '0;
    data_wen_i   = 1'b0;
    data_wdata_i = '0;
    data_be_i    = 4'hF;
    push_valid_i = 1'b0;
    push_data_i  = '0;
    #12;
    test_reset();
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    test_basic();
    test_full();
    test_empty();
    test_wrap();
    test_flush_regs();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
